// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, serviced after LATENCY cycles from a word array.
// Optional misaligned-access error reporting is compiled in with DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              misalign_q, misalign_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];

  logic              from_idle;
  logic              enter_resp;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_bad;
  logic              req_misalign;
  logic              mem_we;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_misalign = (req_addr[1:0] != 2'b00);
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
`else
  assign req_misalign = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

  assign from_idle = (state_q == StIdle);
  assign req_ready = from_idle;

  // With LATENCY=1 the access happens on the acceptance edge, so use the live request fields.
  assign acc_write = from_idle ? req_write : write_q;
  assign acc_idx   = from_idle ? req_addr[ADDR_W+1:2] : idx_q;
  assign acc_wdata = from_idle ? req_wdata : wdata_q;
  assign acc_bad   = from_idle ? req_misalign : misalign_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    misalign_d = misalign_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d    = req_write;
          idx_d      = req_addr[ADDR_W+1:2];
          wdata_d    = req_wdata;
          misalign_d = req_misalign;
          cnt_d      = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    resp_valid_d = enter_resp;
    rdata_d      = rdata_q;
    err_d        = enter_resp && acc_bad;
    mem_we       = enter_resp && acc_write && !acc_bad;
    if (enter_resp && !acc_write && !acc_bad) begin
      rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      misalign_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      misalign_q   <= misalign_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage survives reset; a reset edge must still block a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: three instances (LATENCY 1, 2, 4) against a word-array model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  wire  [2:0]  req_ready;
  wire  [2:0]  resp_valid;
  wire  [2:0]  resp_err;
  wire  [31:0] resp_rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH  (32),
      .ADDR_W (5),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_mem   [3][32];
  logic [31:0] m_rdata [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % 32);
  endfunction

  // Called at a falling edge with instance d idle; returns at a falling edge with d idle again.
  task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    int          lat = lat_of(d);
    logic        bad = is_bad(a);
    logic [31:0] exp_rd = m_rdata[d];
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    check_eq("ready_at_issue", 32'(req_ready[d]), 32'd1);
    if (!bad) begin
      if (w) m_mem[d][word_of(a)] = wd;
      else   exp_rd = m_mem[d][word_of(a)];
    end
    m_rdata[d] = exp_rd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      req_valid[d] = 1'($urandom);
      req_write[d] = 1'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      check_eq("ready_busy", 32'(req_ready[d]), 32'd0);
      check_eq("resp_valid", 32'(resp_valid[d]), 32'(k == lat));
      if (k == lat) begin
        check_eq("resp_rdata", resp_rdata[d], exp_rd);
        check_eq("resp_err", 32'(resp_err[d]), 32'(bad));
      end else begin
        check_eq("err_idle", 32'(resp_err[d]), 32'd0);
      end
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    check_eq("ready_after", 32'(req_ready[d]), 32'd1);
    check_eq("valid_after", 32'(resp_valid[d]), 32'd0);
    check_eq("err_after", 32'(resp_err[d]), 32'd0);
    check_eq("rdata_hold", resp_rdata[d], exp_rd);
  endtask

  initial begin
    logic [31:0] ba [6];
    logic [31:0] old;
    logic [31:0] a;
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    for (int d = 0; d < 3; d++) begin
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      m_rdata[d]   = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_ready", 32'(req_ready[d]), 32'd1);
      check_eq("rst_valid", 32'(resp_valid[d]), 32'd0);
      check_eq("rst_rdata", resp_rdata[d], 32'd0);
      check_eq("rst_err", 32'(resp_err[d]), 32'd0);
    end

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++) do_req(d, 1'b1, 32'(i * 4), $urandom);

    do_req(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(1, 1'b0, 32'h0000_0010, 32'h0);
    do_req(1, 1'b1, 32'h0000_0084, 32'h1234_5678);
    do_req(1, 1'b0, 32'h0000_0004, 32'h0);
    do_req(1, 1'b1, 32'h0000_0022, 32'h0000_0001);
    do_req(1, 1'b0, 32'h0000_0020, 32'h0);
    do_req(2, 1'b0, 32'h0000_0023, 32'h0);

    // LATENCY=1 with valid held high: only every other cycle is accepted.
    for (int c = 0; c < 6; c++) ba[c] = $urandom & 32'hFFFF_FFFC;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      req_valid[0] = (c < 6);
      req_write[0] = 1'b0;
      req_addr[0]  = (c < 6) ? ba[c] : 32'd0;
      check_eq("b2b_ready", 32'(req_ready[0]), 32'(c % 2 == 0));
      check_eq("b2b_valid", 32'(resp_valid[0]), 32'(c % 2 == 1));
      if (c % 2 == 1) check_eq("b2b_rdata", resp_rdata[0], m_mem[0][word_of(ba[c-1])]);
    end
    m_rdata[0] = m_mem[0][word_of(ba[4])];

    // Reset lands two cycles after acceptance of a LATENCY=4 store.
    old = m_mem[2][8];
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h0000_0020;
    req_wdata[2] = 32'hAAAA_5555;
    check_eq("rm_ready", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check_eq("rm_busy", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_eq("rm_valid", 32'(resp_valid[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) m_rdata[d] = 32'd0;
    check_eq("rm_ready_post", 32'(req_ready[2]), 32'd1);
    check_eq("rm_rdata_post", resp_rdata[2], 32'd0);
    repeat (4) begin
      check_eq("rm_no_resp", 32'(resp_valid[2]), 32'd0);
      @(negedge clk);
    end
    do_req(2, 1'b0, 32'h0000_0020, 32'h0);
    check_eq("rm_old_data", m_rdata[2], old);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        do_req(d, 1'($urandom), a, $urandom);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check_eq("gap_valid", 32'(resp_valid[d]), 32'd0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
